rs232_rx: RTL and testbench
===========================

# rs232_rx

UART receiver for the host-to-FPGA link, the counterpart of `rs232_tx`. It lets the PC send single-byte commands and configuration values, such as a DAC code or an ADC channel, into the acquisition top level. It oversamples `rx_i` at the system clock, uses the same runtime `baud_i`/`psel_i` convention as the transmitter, and delivers each byte with a one-cycle `eor_o` strobe plus parity and framing error flags.

## Interface
- `Width`, 15, width of `baud_i`
- `clk_i`  in  1  system clock (100 MHz in the current top level)
- `rst_i`  in  1  synchronous, active-high reset
- `rx_i`  in  1  serial line, asynchronous, idles high
- `baud_i`  in  Width  clocks per bit minus one (867 gives 115200 baud at 100 MHz); held stable while `busy_o`=1
- `psel_i`  in  1  parity select: 0 = even, 1 = odd; sampled at the start bit
- `d_o`  out  8  last received byte; updated only on `eor_o`
- `eor_o`  out  1  end of receive, one-cycle pulse
- `perr_o`  out  1  parity error of the byte in `d_o`
- `ferr_o`  out  1  framing error (stop bit sampled 0) of the byte in `d_o`
- `busy_o`  out  1  high in every state except IDLE

## Operation
- `rx_i` passes through a 2-flop synchronizer. `rx_s` is the output of the second flop. The synchronizer resets to 1.
- Frame: start (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
- Let h = `baud_i`>>1 (half bit) and P = `baud_i`+1 (one bit).
- The bit counter `cnt` is `Width` bits wide. It is cleared on every state entry and at every sample point, then increments by 1 per cycle.
- States and transitions:
  - IDLE: when `rx_s`=0, go to START.
  - START: when `cnt`=h, sample `rx_s`. If 0, go to DATA and latch `psel_i`. If 1 (glitch), go to IDLE with no strobe.
  - DATA: when `cnt`=`baud_i`, shift `rx_s` into bit 7 of the shift register (right shift) and increment the bit index. After the 8th sample, go to PARITY, or to STOP if parity is compiled out.
  - PARITY: when `cnt`=`baud_i`, the error is (XOR of the 8 data bits XOR the parity bit XOR latched `psel_i`). Store it. Go to STOP.
  - STOP: when `cnt`=`baud_i`, sample. On the next cycle:
    - load `d_o`, `perr_o` and `ferr_o` together;
    - pulse `eor_o`;
    - go to IDLE if the stop bit was 1, or to BREAK if it was 0.
  - BREAK: wait until `rx_s`=1, then go to IDLE. This prevents a held-low line from being decoded as 0x00 frames.
- Data is delivered regardless of errors. The flags describe the delivered byte and hold until the next `eor_o`.
- Back-to-back frames: IDLE is reached at the mid-stop point, so a start edge arriving half a bit later is caught.

## Timing
- Cycle 0 is the first cycle in START. Sample points:
  - start bit: cycle h;
  - data bit k (0..7): cycle h + (k+1)·P;
  - parity: cycle h + 9·P;
  - stop: cycle h + 9·P without parity, h + 10·P with parity.
- `eor_o`, `d_o`, `perr_o` and `ferr_o` change one cycle after the stop sample.
- START is entered 3 cycles after the falling edge at `rx_i`: 2 cycles of synchronizer plus 1 cycle for the IDLE decision.
- Reset values:
  - `d_o`=0x00, `eor_o`=0, `perr_o`=0, `ferr_o`=0, `busy_o`=0;
  - state = IDLE, `cnt`=0.
- Reset mid-frame abandons the frame with no strobe. Reception restarts on the next falling edge after reset release.
- `baud_i`=0 is unsupported, since h would be 0. The minimum supported value is 3.

## Configuration
- `RS232_RX_PARITY_EN` defined: PARITY state present, frame is 8E1/8O1 per `psel_i`, `perr_o` live.
- `RS232_RX_PARITY_EN` undefined: frame is 8N1, PARITY state omitted, `psel_i` ignored, `perr_o` tied to 0.
- The macro must match the transmitter's frame format.

## Structure
- Shared package `uart_pkg`:
  - state encoding (IDLE, START, DATA, PARITY, STOP, BREAK);
  - data width constant 8;
  - default baud constant 867;
  - parity select constants.
- One sub-module: `sync_2ff`, a 2-flop synchronizer with reset value 1, reusable for `miso_adc_i`-style asynchronous inputs.

## Test plan
- 0xA5, even parity, `baud_i`=867, clean frame:
  - `eor_o` pulses once;
  - `d_o`=0xA5, `perr_o`=0, `ferr_o`=0;
  - the pulse lands on cycle 433+10·868+1 after START entry.
- 0x3C sent with the wrong parity bit (`psel_i`=1, parity bit sent as 0): `d_o`=0x3C, `perr_o`=1.
- Stop bit forced to 0 on 0x55:
  - `d_o`=0x55, `ferr_o`=1;
  - state holds in BREAK while the line stays low for 5 bit times;
  - no further `eor_o` until the line returns high and a new frame is sent.
- Low glitch of 200 cycles on an idle line: returns to IDLE, no `eor_o`, `d_o` unchanged.
- Three back-to-back frames 0x00, 0xFF, 0x81 with no idle gap: three `eor_o` pulses with matching `d_o` and no flags.
- `rst_i` asserted during bit 4 of a frame:
  - all outputs return to reset values next cycle, with no strobe;
  - the following frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width, baud default
// and parity-select values used by rs232_rx and its transmitter counterpart.
package uart_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int DEFAULT_BAUD = 867;

  localparam logic PSEL_EVEN = 1'b0;
  localparam logic PSEL_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

endpackage

// File: rtl/rs232_rx_if.sv
// Receiver-side bundle: serial line and runtime configuration in, received
// byte, strobe and error flags out.
interface rs232_rx_if #(
  parameter int Width = 15
);
  import uart_pkg::*;

  logic                  rx_i;
  logic [Width-1:0]      baud_i;
  logic                  psel_i;
  logic [DATA_WIDTH-1:0] d_o;
  logic                  eor_o;
  logic                  perr_o;
  logic                  ferr_o;
  logic                  busy_o;

  modport slave (
    input  rx_i, baud_i, psel_i,
    output d_o, eor_o, perr_o, ferr_o, busy_o
  );

  modport master (
    output rx_i, baud_i, psel_i,
    input  d_o, eor_o, perr_o, ferr_o, busy_o
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs; both flops reset
// to RESET_VAL so an idle-high line does not look like an edge after reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta <= RESET_VAL;
      q_o  <= RESET_VAL;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/rs232_rx.sv
// Oversampling UART receiver, 8 data bits LSB first, one stop bit.
// Define RS232_RX_PARITY_EN for an 8E1/8O1 frame; otherwise 8N1 and perr_o stays 0.
module rs232_rx #(
  parameter int Width = 15
) (
  input logic       clk_i,
  input logic       rst_i,
  rs232_rx_if.slave bus
);
  import uart_pkg::*;

  rx_state_t             state;
  logic                  rx_s;
  logic [Width-1:0]      cnt;
  logic [Width-1:0]      half;
  logic [2:0]            bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
`ifdef RS232_RX_PARITY_EN
  logic                  psel_q;
  logic                  perr_q;
`endif

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (bus.rx_i),
    .q_o   (rx_s)
  );

  assign half = bus.baud_i >> 1;

  // cnt restarts at every state entry and sample point, so each bit is
  // sampled baud_i+1 cycles after the previous one, starting mid start-bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      bus.d_o    <= '0;
      bus.eor_o  <= 1'b0;
      bus.perr_o <= 1'b0;
      bus.ferr_o <= 1'b0;
      bus.busy_o <= 1'b0;
`ifdef RS232_RX_PARITY_EN
      psel_q     <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      bus.eor_o <= 1'b0;
      cnt       <= cnt + 1'b1;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state      <= ST_START;
            bus.busy_o <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt == half) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= ST_DATA;
              bit_idx <= '0;
`ifdef RS232_RX_PARITY_EN
              psel_q  <= bus.psel_i;
`endif
            end else begin
              state      <= ST_IDLE;
              bus.busy_o <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (cnt == bus.baud_i) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[DATA_WIDTH-1:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'(DATA_WIDTH - 1)) begin
`ifdef RS232_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end
        end
`ifdef RS232_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt == bus.baud_i) begin
            cnt    <= '0;
            perr_q <= (^shreg) ^ rx_s ^ psel_q;
            state  <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          // Returning to IDLE at mid-stop lets a back-to-back start edge be caught.
          if (cnt == bus.baud_i) begin
            cnt        <= '0;
            bus.d_o    <= shreg;
            bus.eor_o  <= 1'b1;
            bus.ferr_o <= ~rx_s;
`ifdef RS232_RX_PARITY_EN
            bus.perr_o <= perr_q;
`else
            bus.perr_o <= 1'b0;
`endif
            if (rx_s) begin
              state      <= ST_IDLE;
              bus.busy_o <= 1'b0;
            end else begin
              state <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          cnt <= '0;
          if (rx_s) begin
            state      <= ST_IDLE;
            bus.busy_o <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          cnt        <= '0;
          bus.busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_rx.sv
// Self-checking bench for rs232_rx: a frame-level model predicts every strobe,
// its cycle and the held output flags; directed literals pin the model.
module tb_rs232_rx;
  import uart_pkg::*;

`ifdef RS232_RX_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif
  // Index of the stop bit within the frame (start bit is index 0).
  localparam int NB = PARITY_ON ? 10 : 9;

  typedef struct {
    logic [7:0] d;
    logic       perr;
    logic       ferr;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_q = 1'b1;
  int   cyc = 0;
  int   passCount = 0;
  int   checkCount = 0;
  int   eorCount = 0;
  int   lastEorCyc = 0;
  bit   armed = 1'b0;

  exp_t       exp_q[$];
  exp_t       cmp_e;
  logic [7:0] last_d = 8'h00;
  logic       last_perr = 1'b0;
  logic       last_ferr = 1'b0;

  rs232_rx_if #(.Width(15)) bus ();

  rs232_rx #(.Width(15)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Cycles from the falling edge of rx_i to eor_o being visible:
  // 3 to reach START, stop sample at h + NB*P, outputs one cycle later.
  function automatic int frameLatency(input int baud);
    return (baud >> 1) + NB * (baud + 1) + 4;
  endfunction

  function automatic logic expectedPerr(input logic [7:0] d, input logic pbit, input logic psel);
    return PARITY_ON ? ((^d) ^ pbit ^ psel) : 1'b0;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic psel, input bit badPar,
                               input logic stopBit, input int baud);
    int   p;
    logic pbit;
    exp_t e;
    p          = baud + 1;
    pbit       = (^d) ^ psel ^ badPar;
    bus.baud_i = 15'(baud);
    bus.psel_i = psel;
    e.d        = d;
    e.perr     = expectedPerr(d, pbit, psel);
    e.ferr     = ~stopBit;
    e.due      = cyc + frameLatency(baud);
    exp_q.push_back(e);
    bus.rx_i = 1'b0;
    tick(p);
    for (int k = 0; k < 8; k++) begin
      bus.rx_i = d[k];
      tick(p);
    end
    if (PARITY_ON) begin
      bus.rx_i = pbit;
      tick(p);
    end
    bus.rx_i = stopBit;
    tick(p);
  endtask

  // Model compare: every strobe must match the next predicted frame and its
  // cycle; between strobes the outputs must hold the last delivered frame.
  always @(negedge clk) begin
    if (armed) begin
      if (rst_q) begin
        last_d    = 8'h00;
        last_perr = 1'b0;
        last_ferr = 1'b0;
        checkOutput("reset_busy", bus.busy_o, 0);
        checkOutput("reset_eor", bus.eor_o, 0);
      end else if (bus.eor_o) begin
        eorCount++;
        lastEorCyc = cyc;
        checkOutput("eor_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          cmp_e = exp_q.pop_front();
          checkOutput("eor_cycle", cyc, cmp_e.due);
          last_d    = cmp_e.d;
          last_perr = cmp_e.perr;
          last_ferr = cmp_e.ferr;
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
        checkOutput("missing_eor", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      checkOutput("d_o", bus.d_o, last_d);
      checkOutput("perr_o", bus.perr_o, last_perr);
      checkOutput("ferr_o", bus.ferr_o, last_ferr);
    end
  end

  initial begin
    int t0;
    int n0;
    bus.rx_i   = 1'b1;
    bus.baud_i = 15'd867;
    bus.psel_i = PSEL_EVEN;
    rst        = 1'b1;
    tick(3);
    armed = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    checkOutput("rst_d_o", bus.d_o, 8'h00);
    checkOutput("rst_busy", bus.busy_o, 0);
    checkOutput("rst_flags", {bus.eor_o, bus.perr_o, bus.ferr_o}, 3'b000);

    $display("[TB] clean frame 0xA5 at baud 867");
    t0 = cyc;
    n0 = eorCount;
    applyStimulus(8'hA5, PSEL_EVEN, 1'b0, 1'b1, 867);
    tick(4);
    checkOutput("a5_latency", lastEorCyc - t0, PARITY_ON ? 9117 : 8249);
    checkOutput("a5_eor_count", eorCount - n0, 1);
    checkOutput("a5_d_o", bus.d_o, 8'hA5);
    checkOutput("a5_flags", {bus.perr_o, bus.ferr_o}, 2'b00);

    $display("[TB] 200-cycle glitch on idle line");
    n0 = eorCount;
    bus.rx_i = 1'b0;
    tick(200);
    bus.rx_i = 1'b1;
    tick(10);
    checkOutput("glitch_busy_in_start", bus.busy_o, 1);
    tick(300);
    checkOutput("glitch_busy_idle", bus.busy_o, 0);
    checkOutput("glitch_no_eor", eorCount - n0, 0);
    checkOutput("glitch_d_o", bus.d_o, 8'hA5);

    $display("[TB] 0x3C with wrong parity bit");
    applyStimulus(8'h3C, PSEL_ODD, 1'b1, 1'b1, 15);
    tick(4);
    checkOutput("3c_d_o", bus.d_o, 8'h3C);
    checkOutput("3c_perr", bus.perr_o, PARITY_ON ? 1 : 0);
    checkOutput("3c_ferr", bus.ferr_o, 0);

    $display("[TB] 0x55 with stop bit low, then held low");
    n0 = eorCount;
    applyStimulus(8'h55, PSEL_EVEN, 1'b0, 1'b0, 15);
    for (int i = 0; i < 5; i++) begin
      tick(16);
      checkOutput("break_busy", bus.busy_o, 1);
    end
    checkOutput("break_eor_count", eorCount - n0, 1);
    checkOutput("55_d_o", bus.d_o, 8'h55);
    checkOutput("55_ferr", bus.ferr_o, 1);
    checkOutput("55_perr", bus.perr_o, 0);
    bus.rx_i = 1'b1;
    tick(4);
    checkOutput("break_exit_busy", bus.busy_o, 0);
    tick(16);
    applyStimulus(8'hC3, PSEL_EVEN, 1'b0, 1'b1, 15);
    tick(4);
    checkOutput("c3_d_o", bus.d_o, 8'hC3);
    checkOutput("c3_flags", {bus.perr_o, bus.ferr_o}, 2'b00);

    $display("[TB] back-to-back frames 0x00 0xFF 0x81");
    n0 = eorCount;
    applyStimulus(8'h00, PSEL_EVEN, 1'b0, 1'b1, 15);
    applyStimulus(8'hFF, PSEL_EVEN, 1'b0, 1'b1, 15);
    applyStimulus(8'h81, PSEL_EVEN, 1'b0, 1'b1, 15);
    tick(8);
    checkOutput("b2b_eor_count", eorCount - n0, 3);
    checkOutput("b2b_d_o", bus.d_o, 8'h81);
    checkOutput("b2b_flags", {bus.perr_o, bus.ferr_o}, 2'b00);

    $display("[TB] reset during data bit 4");
    n0 = eorCount;
    bus.rx_i = 1'b0;
    tick(16);
    for (int k = 0; k < 4; k++) begin
      bus.rx_i = k[0];
      tick(16);
    end
    bus.rx_i = 1'b1;
    tick(8);
    rst = 1'b1;
    tick(1);
    checkOutput("midrst_d_o", bus.d_o, 8'h00);
    checkOutput("midrst_busy", bus.busy_o, 0);
    checkOutput("midrst_flags", {bus.eor_o, bus.perr_o, bus.ferr_o}, 3'b000);
    rst = 1'b0;
    tick(40);
    checkOutput("midrst_no_eor", eorCount - n0, 0);
    checkOutput("midrst_idle", bus.busy_o, 0);
    applyStimulus(8'h7E, PSEL_EVEN, 1'b0, 1'b1, 15);
    tick(8);
    checkOutput("7e_d_o", bus.d_o, 8'h7E);
    checkOutput("7e_flags", {bus.perr_o, bus.ferr_o}, 2'b00);
    checkOutput("7e_eor_count", eorCount - n0, 1);

    tick(20);
    checkOutput("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
